// File: rtl/johnson_rx_checker.sv
// Receive-side Johnson counter checker: decodes each sampled code to a phase index,
// flags illegal codes, tracks sequence lock and counts sequence errors.
module johnson_rx_checker #(
    parameter  int N        = 4,
    parameter  int LOCK_CNT = 3,
    localparam int PW       = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  in,
    input  logic          in_valid,
    output logic [PW-1:0] phase,
    output logic          phase_valid,
    output logic          locked,
    output logic          illegal,
    output logic          err,
    output logic [7:0]    err_count
);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    localparam logic [N-1:0]  ONE_N      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   TWO_N      = (PW+1)'(2 * N);
    localparam logic [PW-1:0] LAST_PHASE = PW'(2 * N - 1);
    localparam logic [3:0]    LOCK_TGT   = 4'(LOCK_CNT);

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic            have_prev_q, have_prev_d;
    logic [3:0]      match_q, match_d;
    logic            pv_q, pv_d;
    logic            ill_q, ill_d;
    logic            err_q, err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic [N-1:0]    inv;
    logic            legal;
    logic [PW:0]     ones;
    logic [PW:0]     dec_wide;
    logic [PW-1:0]   dec;
    logic [PW-1:0]   exp_phase;
    logic [3:0]      match_inc;
    logic            err_hit;

    // Ones anchored at the LSB satisfy x & (x+1) == 0; MSB-anchored codes are their complement.
    assign inv   = ~in;
    assign legal = ((in & (in + ONE_N)) == '0) || ((inv & (inv + ONE_N)) == '0);

    always_comb begin
        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + (PW+1)'(in[i]);
        end
    end

    assign dec_wide  = in[N-1] ? (TWO_N - ones) : ones;
    assign dec       = dec_wide[PW-1:0];
    // phase always equals the last legal sample, so it doubles as the previous phase.
    assign exp_phase = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
    assign match_inc = match_q + 4'd1;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        have_prev_d = have_prev_q;
        match_d     = match_q;
        pv_d        = 1'b0;
        ill_d       = 1'b0;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        err_hit     = 1'b0;

        if (in_valid) begin
            if (!legal) begin
                ill_d       = 1'b1;
                have_prev_d = 1'b0;
                match_d     = '0;
                if (state_q == LOCKED) begin
                    err_hit = 1'b1;
                    state_d = HUNT;
                end
            end else begin
                phase_d     = dec;
                pv_d        = 1'b1;
                have_prev_d = 1'b1;
                case (state_q)
                    HUNT: begin
                        if (have_prev_q && (dec == exp_phase)) begin
                            if (match_inc == LOCK_TGT) begin
                                state_d = LOCKED;
                                match_d = '0;
                            end else begin
                                match_d = match_inc;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (dec != exp_phase) begin
                            err_hit = 1'b1;
                            state_d = HUNT;
                            match_d = '0;
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
        end

        if (err_hit) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            phase_q     <= '0;
            have_prev_q <= 1'b0;
            match_q     <= '0;
            pv_q        <= 1'b0;
            ill_q       <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q     <= state_d;
            phase_q     <= phase_d;
            have_prev_q <= have_prev_d;
            match_q     <= match_d;
            pv_q        <= pv_d;
            ill_q       <= ill_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = pv_q;
    assign locked      = (state_q == LOCKED);
    assign illegal     = ill_q;
    assign err         = err_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_johnson_rx_checker.sv
// Scoreboard bench for johnson_rx_checker (N=4, LOCK_CNT=3): the driver queues the
// hand-derived response for each valid sample, the monitor pops it when the DUT responds.
module tb_johnson_rx_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] j_in;
    logic       in_valid;
    logic [2:0] phase;
    logic       phase_valid;
    logic       locked;
    logic       illegal;
    logic       err;
    logic [7:0] err_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [31:0] exp_q [$];
    logic [3:0]  jc [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

    johnson_rx_checker #(.N(4), .LOCK_CNT(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (j_in),
        .in_valid   (in_valid),
        .phase      (phase),
        .phase_valid(phase_valid),
        .locked     (locked),
        .illegal    (illegal),
        .err        (err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input logic pv, input logic [2:0] ph, input logic lk,
                                         input logic il, input logic er, input logic [7:0] cnt);
        return {17'b0, pv, ph, lk, il, er, cnt};
    endfunction

    function automatic logic [31:0] dut_word();
        return pack(phase_valid, phase, locked, illegal, err, err_count);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("FAIL %s: got %08h required %08h", name, act, req);
        end
    endtask

    task automatic send(input logic [3:0] code, input logic pv, input logic [2:0] ph,
                        input logic lk, input logic il, input logic er, input logic [7:0] cnt);
        @(negedge clk);
        j_in     = code;
        in_valid = 1'b1;
        exp_q.push_back(pack(pv, ph, lk, il, er, cnt));
    endtask

    task automatic idle(input logic [2:0] ph, input logic lk, input logic [7:0] cnt);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_hold", dut_word(), pack(1'b0, ph, lk, 1'b0, 1'b0, cnt));
    endtask

    // Monitor: every consumed sample yields either phase_valid or illegal.
    always @(negedge clk) begin
        if (!reset && (phase_valid || illegal)) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL unexpected_output: got %08h required no output", dut_word());
            end else begin
                check("sample", dut_word(), exp_q.pop_front());
            end
        end
    end

    initial begin
        int cur;
        logic [7:0] cnt;

        reset    = 1'b1;
        j_in     = 4'b0000;
        in_valid = 1'b0;
        #3;
        check("reset_state", dut_word(), '0);
        #7;
        reset = 1'b0;

        // 12 samples from 0000: lock after the 4th, wrap 1000 -> 0000 while locked.
        for (int i = 0; i < 12; i++) begin
            send(jc[i % 8], 1'b1, 3'(i % 8), (i >= 3), 1'b0, 1'b0, 8'd0);
        end
        // Continue to phase 2 (0011), then skip 0111 by driving 1111.
        for (int i = 12; i < 19; i++) begin
            send(jc[i % 8], 1'b1, 3'(i % 8), 1'b1, 1'b0, 1'b0, 8'd0);
        end
        send(4'b1111, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 8'd1);
        send(4'b1110, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 8'd1);
        send(4'b1100, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 8'd1);
        send(4'b1000, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 8'd1);
        send(4'b0000, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1);

        // Illegal code while locked, then another in HUNT (no err there).
        send(4'b0101, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'd2);
        send(4'b1010, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd2);
        // History was dropped: four samples needed to relock.
        send(4'b0000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'd2);
        send(4'b0001, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd2);
        send(4'b0011, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd2);
        send(4'b0111, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'd2);

        // Gapped valid: idle cycles hold state and pulse nothing.
        send(4'b1111, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'd2);
        idle(3'd4, 1'b1, 8'd2);
        send(4'b1110, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 8'd2);
        idle(3'd5, 1'b1, 8'd2);
        send(4'b1100, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 8'd2);
        idle(3'd6, 1'b1, 8'd2);
        send(4'b1000, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 8'd2);
        idle(3'd7, 1'b1, 8'd2);

        // Three more skip errors bring err_count to 5, relocking after each.
        cur = 7;
        for (int k = 0; k < 3; k++) begin
            cur = (cur + 2) % 8;
            send(jc[cur], 1'b1, 3'(cur), 1'b0, 1'b0, 1'b1, 8'(3 + k));
            for (int s = 1; s <= 3; s++) begin
                cur = (cur + 1) % 8;
                send(jc[cur], 1'b1, 3'(cur), (s == 3), 1'b0, 1'b0, 8'(3 + k));
            end
        end

        // Asynchronous reset between clock edges while locked.
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset", {22'b0, locked, 1'b0, err_count}, {22'b0, 1'b1, 1'b0, 8'd5});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", dut_word(), '0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Lock, then 300 skip errors: err_count saturates at 255, err keeps pulsing.
        for (int i = 0; i < 4; i++) begin
            send(jc[i], 1'b1, 3'(i), (i == 3), 1'b0, 1'b0, 8'd0);
        end
        cur = 3;
        for (int k = 0; k < 300; k++) begin
            cnt = (k + 1 > 255) ? 8'd255 : 8'(k + 1);
            cur = (cur + 2) % 8;
            send(jc[cur], 1'b1, 3'(cur), 1'b0, 1'b0, 1'b1, cnt);
            for (int s = 1; s <= 3; s++) begin
                cur = (cur + 1) % 8;
                send(jc[cur], 1'b1, 3'(cur), (s == 3), 1'b0, 1'b0, cnt);
            end
        end

        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        check("drain_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/johnson_rx_checker.md
Name: johnson_rx_checker

Overview:
- Receive-side decoder and monitor for the N-bit Johnson (twisted-ring) counter stream produced by the team's counter blocks.
- Converts each sampled Johnson code to a binary phase index and checks that the code is legal.
- Tracks sequence lock and counts sequence errors, so the counter output can be self-checked in system or on the bench.

Parameters:
- N, 4, Johnson code width; the sequence has 2N states.
- LOCK_CNT, 3, consecutive correct successor transitions required to declare lock (1..15).
- PW, $clog2(2N), width of the phase index (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  N  Johnson code sample.
- in_valid  input  1  in is sampled on this clock edge when high.
- phase  output  PW  decoded phase index of the last legal sample.
- phase_valid  output  1  one-cycle pulse: phase was updated from a legal sample.
- locked  output  1  high while the sequence is locked.
- illegal  output  1  one-cycle pulse: the sampled code is not a Johnson code.
- err  output  1  one-cycle pulse: sequence error while locked.
- err_count  output  8  saturating count of err pulses.

Behaviour:
- Reset (asynchronous, active-high):
  - phase=0, phase_valid=0, locked=0, illegal=0, err=0, err_count=0.
  - Internal match counter=0; FSM=HUNT; prev_phase=0; have_prev=0.
  - Reset mid-stream discards lock and history. err_count clears only on reset.
- Johnson sequence convention: next = {q[N-2:0], ~q[N-1]}. For N=4: 0000,0001,0011,0111,1111,1110,1100,1000, then wraps to 0000. Phases are 0..7 in that order.
- Legality: a code is legal iff it is 0…01…1 (ones anchored at the LSB, including all-zero) or 1…10…0 (ones anchored at the MSB, including all-ones). All other codes are illegal.
- Decode (combinational, on the sample): c = popcount(in).
  - If in[N-1]==0: phase = c.
  - Else: phase = 2N − c. This gives all-ones → N.
- Latency: all outputs are registered, one cycle after the in_valid edge. When in_valid=0, the pulse outputs are 0 and all other state holds.
- Expected successor: exp = (prev_phase + 1) mod 2N. Wrap is 2N−1 → 0.
- FSM states: HUNT, LOCKED.
- HUNT:
  - Legal sample:
    - phase and prev_phase are updated; phase_valid pulses.
    - If have_prev and phase == exp: match counter increments. Otherwise the match counter resets to 0.
    - have_prev is set to 1.
    - When the match counter reaches LOCK_CNT: go to LOCKED, locked=1 on the same registered edge, match counter clears.
  - Illegal sample:
    - illegal pulses; phase holds; match counter=0; have_prev=0.
    - No err pulse, and err_count unchanged, while in HUNT.
- LOCKED:
  - Legal sample equal to exp: phase updates, phase_valid pulses, stay LOCKED.
  - Legal sample not equal to exp (skip, repeat, or reverse):
    - err pulses; err_count increments; go to HUNT; locked=0.
    - phase and prev_phase take the new sample; phase_valid pulses; have_prev=1; match counter=0.
  - Illegal sample:
    - illegal and err both pulse; err_count increments; go to HUNT; locked=0.
    - phase holds; have_prev=0.
- err_count saturates at 255. Further errors still pulse err.
- Simultaneous reset and in_valid: reset wins.

Test Plan:
- Reset asserted for 10 ns, then the N=4 sequence driven from 0000 with in_valid=1 every cycle:
  - phase_valid pulses every cycle, phase = 0,1,2,…
  - locked rises one cycle after the 4th sample (3 correct transitions).
  - err_count=0 after 12 samples.
- Wrap check: locked stream crosses 1000 → 0000: phase goes 7 → 0, locked stays 1, no err.
- Skip error: while locked, drive 0011 then 1111 (skip 0111):
  - err pulses once, locked=0, err_count=1, phase=4.
  - Relocks after 3 further correct transitions.
- Illegal code: while locked, drive 0101:
  - illegal=1 and err=1 for one cycle; locked=0; phase holds its previous value; err_count increments.
  - In HUNT, 1010 gives illegal=1, err=0, and err_count unchanged.
- Gapped valid: locked stream with in_valid toggling 1,0,1,0: correct successors are only checked on valid cycles; no err; outputs hold on idle cycles.
- Reset mid-operation and saturation:
  - Assert reset while locked with err_count=5: all outputs go to 0 immediately (asynchronously).
  - Force 300 skip errors: err_count stops at 255 and err keeps pulsing.
